// File: rtl/mp_pwr_seq_ctrl_usb4_if.sv
// Bundle of the MAC-side powerdown request, the PMA power/clock handshake
// and the sequencer status outputs for one USB4 PIPE6 lane.
//
// Handshake semantics: the sequencer drives a request level (one-hot power
// state on pma_power_state_req, or the clock enable on pma_xcvr_pll_clk_en)
// and holds it until the PMA returns the same level on the matching ack
// (pma_power_state_ack == pma_power_state_req, or
// pma_xcvr_pll_clk_en_ack == pma_xcvr_pll_clk_en). Acks are level-based:
// they are sampled every cycle with no pipelining. Nothing is transferred
// by a one-cycle strobe, and no request is withdrawn before its ack matches,
// except when a timeout expires, the PLL drops, or reset is asserted.
// pwr_chg_done is a one-cycle completion pulse with no back-pressure.
interface mp_pwr_seq_ctrl_usb4_if;
  logic [2:0] pipe_powerdown;
  logic       pma_pll_ready;
  logic [5:0] pma_power_state_ack;
  logic       pma_xcvr_pll_clk_en_ack;
  logic [5:0] pma_power_state_req;
  logic       pma_xcvr_pll_clk_en;
  logic       pwr_chg_done;
  logic [2:0] cur_pwr_state;
  logic       pipe_rx_en;
  logic       busy;
  logic       pwr_chg_err;
  logic [2:0] fsm_state;

  // MAC/PMA side
  modport master (
    output pipe_powerdown, pma_pll_ready, pma_power_state_ack, pma_xcvr_pll_clk_en_ack,
    input  pma_power_state_req, pma_xcvr_pll_clk_en, pwr_chg_done, cur_pwr_state,
           pipe_rx_en, busy, pwr_chg_err, fsm_state
  );

  // Sequencer side
  modport slave (
    input  pipe_powerdown, pma_pll_ready, pma_power_state_ack, pma_xcvr_pll_clk_en_ack,
    output pma_power_state_req, pma_xcvr_pll_clk_en, pwr_chg_done, cur_pwr_state,
           pipe_rx_en, busy, pwr_chg_err, fsm_state
  );
endinterface

// File: rtl/mp_pwr_seq_ctrl_usb4.sv
// Power-state change sequencer for one USB4 PIPE6 PCS lane (psm_clk domain).
// Converts a PIPE powerdown code into: request clear, transceiver clock
// enable/disable, one-hot PMA power-state request, then a done pulse.
// Optional macro CDN_PWR_SEQ_TIMEOUT_EN adds the wait-state timeout counter
// and the sticky pwr_chg_err flag; without it wait states wait forever.
// All outputs are registered; the current FSM state is exported as fsm_state.
module mp_pwr_seq_ctrl_usb4 #(
  parameter int unsigned ACK_TIMEOUT = 4096
) (
  input logic psm_clk,
  input logic psm_rst,
  mp_pwr_seq_ctrl_usb4_if.slave bus
);

  typedef enum logic [2:0] {
    S_WAIT_PLL = 3'd0,
    S_IDLE     = 3'd1,
    S_REQ_CLR  = 3'd2,
    S_CLK_ON   = 3'd3,
    S_REQ      = 3'd4,
    S_CLK_OFF  = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [2:0] P0 = 3'd0;
  localparam logic [2:0] P2 = 3'd3;

  state_t     state, state_next;
  logic [2:0] target, target_next;
  logic [2:0] cur, cur_next;
  logic [5:0] req;
  logic       clk_en, done, rx_en, busy, err;
  logic       init_seq;
  logic       tmo;
  logic       err_set;

  function automatic logic [5:0] onehot(input logic [2:0] code);
    case (code)
      3'd0:    onehot = 6'h01;
      3'd1:    onehot = 6'h02;
      3'd2:    onehot = 6'h04;
      3'd3:    onehot = 6'h08;
      default: onehot = 6'h00;
    endcase
  endfunction

  // Next-state, target latch and completed-state update
  always_comb begin
    state_next  = state;
    target_next = target;
    cur_next    = cur;
    err_set     = 1'b0;
    case (state)
      S_WAIT_PLL: begin
        if (bus.pma_pll_ready) begin
          target_next = P2;
          state_next  = S_REQ_CLR;
        end
      end
      S_IDLE: begin
        // codes 4-7 are reserved and never start a sequence
        if (!bus.pipe_powerdown[2] && (bus.pipe_powerdown != cur)) begin
          target_next = bus.pipe_powerdown;
          state_next  = S_REQ_CLR;
        end
      end
      S_REQ_CLR: begin
        if ((bus.pma_power_state_ack == 6'h00) || tmo) begin
          err_set    = (bus.pma_power_state_ack != 6'h00);
          // P0/P0s need the transceiver clock running before the request
          state_next = (!target[1] && !clk_en) ? S_CLK_ON : S_REQ;
        end
      end
      S_CLK_ON: begin
        if (bus.pma_xcvr_pll_clk_en_ack || tmo) begin
          err_set    = !bus.pma_xcvr_pll_clk_en_ack;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        if ((bus.pma_power_state_ack == req) || tmo) begin
          err_set    = (bus.pma_power_state_ack != req);
          // P1/P2 stop the clock only after the PMA has entered the state
          state_next = (target[1] && clk_en) ? S_CLK_OFF : S_DONE;
        end
      end
      S_CLK_OFF: begin
        if (!bus.pma_xcvr_pll_clk_en_ack || tmo) begin
          err_set    = bus.pma_xcvr_pll_clk_en_ack;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        cur_next   = target;
        state_next = S_IDLE;
      end
      default: state_next = S_WAIT_PLL;
    endcase
    // Losing the common PLL aborts whatever is in flight
    if ((state != S_WAIT_PLL) && !bus.pma_pll_ready) begin
      state_next = S_WAIT_PLL;
      cur_next   = 3'd3;
    end
  end

  // State register, target and initial-sequence marker
  always_ff @(posedge psm_clk) begin
    if (psm_rst) begin
      state    <= S_WAIT_PLL;
      target   <= P2;
      init_seq <= 1'b0;
    end else begin
      state  <= state_next;
      target <= target_next;
      if ((state == S_WAIT_PLL) && (state_next == S_REQ_CLR)) begin
        init_seq <= 1'b1;
      end else if (state == S_DONE) begin
        init_seq <= 1'b0;
      end
    end
  end

  // Registered outputs, computed from the state being entered
  always_ff @(posedge psm_clk) begin
    if (psm_rst) begin
      req    <= 6'h00;
      clk_en <= 1'b0;
      done   <= 1'b0;
      cur    <= 3'd3;
      rx_en  <= 1'b0;
      busy   <= 1'b1;
    end else begin
      done  <= 1'b0;
      rx_en <= 1'b0;
      busy  <= 1'b1;
      cur   <= cur_next;
      case (state_next)
        S_WAIT_PLL: begin
          req    <= 6'h00;
          clk_en <= 1'b0;
        end
        S_IDLE: begin
          busy  <= 1'b0;
          rx_en <= (cur_next == P0);
        end
        S_REQ_CLR: req    <= 6'h00;
        S_CLK_ON:  clk_en <= 1'b1;
        S_REQ:     req    <= onehot(target_next);
        S_CLK_OFF: clk_en <= 1'b0;
        S_DONE:    done   <= !init_seq;
        default: ;
      endcase
    end
  end

`ifdef CDN_PWR_SEQ_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(ACK_TIMEOUT - 1);
  logic [15:0] cnt;
  logic        wait_st;

  assign wait_st = (state == S_REQ_CLR) || (state == S_CLK_ON) ||
                   (state == S_REQ) || (state == S_CLK_OFF);
  assign tmo     = wait_st && (cnt == TMO_LIMIT);

  // Wait-state cycle counter, restarted on every state entry
  always_ff @(posedge psm_clk) begin
    if (psm_rst) begin
      cnt <= 16'd0;
    end else if (state_next != state) begin
      cnt <= 16'd0;
    end else if (wait_st) begin
      cnt <= cnt + 16'd1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  // Sticky timeout flag; only reset clears it
  always_ff @(posedge psm_clk) begin
    if (psm_rst) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end
  end

  assign bus.pma_power_state_req = req;
  assign bus.pma_xcvr_pll_clk_en = clk_en;
  assign bus.pwr_chg_done        = done;
  assign bus.cur_pwr_state       = cur;
  assign bus.pipe_rx_en          = rx_en;
  assign bus.busy                = busy;
  assign bus.pwr_chg_err         = err;
  assign bus.fsm_state           = state;

endmodule

// File: tb/tb_mp_pwr_seq_ctrl_usb4.sv
// Bench for mp_pwr_seq_ctrl_usb4. A PMA model answers combinationally
// (ack = req, clk_en_ack = clk_en) unless a test takes manual control.
// Expected completed states are queued when a change is requested and
// popped when the done pulse is seen. Build with CDN_PWR_SEQ_TIMEOUT_EN
// defined to exercise the timeout path with ACK_TIMEOUT=16.
module tb_mp_pwr_seq_ctrl_usb4;

  localparam logic [2:0] ST_WAIT_PLL = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_CLK_ON   = 3'd3;
  localparam logic [2:0] ST_REQ      = 3'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       man_ack_en = 1'b0;
  logic [5:0] man_ack = 6'h00;
  logic       man_clk_en = 1'b0;
  logic       man_clk_ack = 1'b0;

  int         n_run  = 0;
  int         n_fail = 0;
  int         done_cnt = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_v;

  mp_pwr_seq_ctrl_usb4_if bus();

  assign bus.pma_power_state_ack     = man_ack_en ? man_ack : bus.pma_power_state_req;
  assign bus.pma_xcvr_pll_clk_en_ack = man_clk_en ? man_clk_ack : bus.pma_xcvr_pll_clk_en;

`ifdef CDN_PWR_SEQ_TIMEOUT_EN
  mp_pwr_seq_ctrl_usb4 #(.ACK_TIMEOUT(16)) dut (.psm_clk(clk), .psm_rst(rst), .bus(bus));
`else
  mp_pwr_seq_ctrl_usb4 dut (.psm_clk(clk), .psm_rst(rst), .bus(bus));
`endif

  // clock / pulse counter
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.pwr_chg_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < budget) begin
      step();
      cyc++;
      if (bus.pwr_chg_done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_run++;
    if ({bus.pma_power_state_req, bus.pma_xcvr_pll_clk_en, bus.pwr_chg_done, bus.cur_pwr_state,
         bus.pipe_rx_en, bus.busy, bus.pwr_chg_err, bus.fsm_state} !==
        {6'h00, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, ST_WAIT_PLL}) begin
      n_fail++;
      $display("FAIL %s: req=%h clk_en=%b done=%b cur=%0d rx_en=%b busy=%b err=%b st=%0d, want 00 0 0 3 0 1 0 0",
               tag, bus.pma_power_state_req, bus.pma_xcvr_pll_clk_en, bus.pwr_chg_done,
               bus.cur_pwr_state, bus.pipe_rx_en, bus.busy, bus.pwr_chg_err, bus.fsm_state);
    end
  endtask

  task automatic test_reset();
    int  d0;
    int  cyc;
    bit  fell;
    rst = 1'b1;
    bus.pma_pll_ready = 1'b0;
    bus.pipe_powerdown = 3'd3;
    repeat (3) step();
    check_reset_values("reset_values");
    rst = 1'b0;
    d0 = done_cnt;
    repeat (4) step();
    check_reset_values("wait_pll_hold");
    bus.pma_pll_ready = 1'b1;
    step();
    n_run++;
    if (bus.pma_power_state_req !== 6'h00) begin
      n_fail++;
      $display("FAIL init_req_clr: req=%h want 00", bus.pma_power_state_req);
    end
    cyc = 0;
    fell = 1'b0;
    while (!fell && cyc < 20) begin
      step();
      cyc++;
      if (bus.busy === 1'b0) fell = 1'b1;
    end
    n_run++;
    if (fell !== 1'b1) begin
      n_fail++;
      $display("FAIL init_busy_fall: busy=%b want 0 within 20 cycles", bus.busy);
    end
    n_run++;
    if ({bus.pma_power_state_req, bus.pma_xcvr_pll_clk_en, bus.cur_pwr_state} !== {6'h08, 1'b0, 3'd3}) begin
      n_fail++;
      $display("FAIL init_end: req=%h clk_en=%b cur=%0d want 08 0 3",
               bus.pma_power_state_req, bus.pma_xcvr_pll_clk_en, bus.cur_pwr_state);
    end
    n_run++;
    if (done_cnt - d0 !== 0) begin
      n_fail++;
      $display("FAIL init_no_done: pulses=%0d want 0", done_cnt - d0);
    end
  endtask

  task automatic test_p2_to_p0();
    int d0;
    int cyc;
    int first_clk;
    int first_req;
    bit seen;
    d0 = done_cnt;
    bus.pipe_powerdown = 3'd0;
    exp_q.push_back(3'd0);
    cyc = 0; first_clk = 0; first_req = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      step();
      cyc++;
      if (cyc == 1) begin
        n_run++;
        if (bus.pma_power_state_req !== 6'h00) begin
          n_fail++;
          $display("FAIL p0_req_clr: req=%h want 00", bus.pma_power_state_req);
        end
      end
      if (bus.pma_xcvr_pll_clk_en === 1'b1 && first_clk == 0) first_clk = cyc;
      if (bus.pma_power_state_req === 6'h01 && first_req == 0) first_req = cyc;
      if (bus.pwr_chg_done === 1'b1) seen = 1'b1;
    end
    n_run++;
    if (!seen || cyc != 4) begin
      n_fail++;
      $display("FAIL p0_latency: seen=%b cycles=%0d want 1 4", seen, cyc);
    end
    n_run++;
    if (first_clk != 2 || first_req != 3) begin
      n_fail++;
      $display("FAIL p0_order: clk_en at %0d req at %0d want 2 3", first_clk, first_req);
    end
    step();
    exp_v = exp_q.pop_front();
    n_run++;
    if ({bus.cur_pwr_state, bus.pipe_rx_en, bus.pwr_chg_done} !== {exp_v, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL p0_after: cur=%0d rx_en=%b done=%b want %0d 1 0",
               bus.cur_pwr_state, bus.pipe_rx_en, bus.pwr_chg_done, exp_v);
    end
    n_run++;
    if (done_cnt - d0 !== 1) begin
      n_fail++;
      $display("FAIL p0_pulses: pulses=%0d want 1", done_cnt - d0);
    end
  endtask

  task automatic test_p0_to_p0s();
    int cyc;
    bit seen;
    logic [2:0] codes[2];
    logic       rx[2];
    codes[0] = 3'd1; codes[1] = 3'd0;
    rx[0] = 1'b0;    rx[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.pipe_powerdown = codes[i];
      exp_q.push_back(codes[i]);
      wait_done(20, cyc, seen);
      n_run++;
      if (!seen || cyc != 3) begin
        n_fail++;
        $display("FAIL p0s_latency[%0d]: seen=%b cycles=%0d want 1 3", i, seen, cyc);
      end
      step();
      exp_v = exp_q.pop_front();
      n_run++;
      if ({bus.cur_pwr_state, bus.pipe_rx_en} !== {exp_v, rx[i]}) begin
        n_fail++;
        $display("FAIL p0s_state[%0d]: cur=%0d rx_en=%b want %0d %b",
                 i, bus.cur_pwr_state, bus.pipe_rx_en, exp_v, rx[i]);
      end
    end
  endtask

  task automatic test_delayed_ack();
    int d0;
    int cyc;
    int bad;
    bit seen;
    d0 = done_cnt;
    man_ack = 6'h01;
    man_ack_en = 1'b1;
    bus.pipe_powerdown = 3'd2;
    exp_q.push_back(3'd2);
    step();
    n_run++;
    if (bus.pipe_rx_en !== 1'b0) begin
      n_fail++;
      $display("FAIL dly_rx_off: rx_en=%b want 0", bus.pipe_rx_en);
    end
    if (bus.pma_power_state_req === 6'h00) man_ack = 6'h00;
    cyc = 0;
    while (bus.pma_power_state_req !== 6'h04 && cyc < 10) begin
      step();
      cyc++;
      if (bus.pma_power_state_req === 6'h00) man_ack = 6'h00;
    end
    n_run++;
    if (bus.pma_power_state_req !== 6'h04) begin
      n_fail++;
      $display("FAIL dly_req: req=%h want 04", bus.pma_power_state_req);
    end
    bad = 0;
    repeat (10) begin
      step();
      if (bus.pma_xcvr_pll_clk_en !== 1'b1 || bus.fsm_state !== ST_REQ) bad++;
    end
    n_run++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL dly_hold: %0d cycles left REQ or dropped clk_en early, want 0", bad);
    end
    man_ack = 6'h04;
    wait_done(10, cyc, seen);
    n_run++;
    if (!seen || cyc != 2 || bus.pma_xcvr_pll_clk_en !== 1'b0) begin
      n_fail++;
      $display("FAIL dly_done: seen=%b cycles=%0d clk_en=%b want 1 2 0", seen, cyc, bus.pma_xcvr_pll_clk_en);
    end
    step();
    exp_v = exp_q.pop_front();
    man_ack_en = 1'b0;
    n_run++;
    if ({bus.cur_pwr_state, bus.pipe_rx_en} !== {exp_v, 1'b0} || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL dly_after: cur=%0d rx_en=%b pulses=%0d want %0d 0 1",
               bus.cur_pwr_state, bus.pipe_rx_en, done_cnt - d0, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    int cyc;
    bit seen;
    bus.pipe_powerdown = 3'd0;
    exp_q.push_back(3'd0);
    wait_done(20, cyc, seen);
    step();
    exp_v = exp_q.pop_front();
    n_run++;
    if (!seen || bus.cur_pwr_state !== exp_v) begin
      n_fail++;
      $display("FAIL b2b_pre: seen=%b cur=%0d want 1 %0d", seen, bus.cur_pwr_state, exp_v);
    end
    d0 = done_cnt;
    bus.pipe_powerdown = 3'd2;
    exp_q.push_back(3'd2);
    step();
    step();
    n_run++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_busy: busy=%b want 1", bus.busy);
    end
    bus.pipe_powerdown = 3'd0;
    exp_q.push_back(3'd0);
    wait_done(30, cyc, seen);
    step();
    exp_v = exp_q.pop_front();
    n_run++;
    if (!seen || bus.cur_pwr_state !== exp_v || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: seen=%b cur=%0d busy=%b want 1 %0d 0", seen, bus.cur_pwr_state, bus.busy, exp_v);
    end
    wait_done(30, cyc, seen);
    step();
    exp_v = exp_q.pop_front();
    n_run++;
    if (!seen || bus.cur_pwr_state !== exp_v) begin
      n_fail++;
      $display("FAIL b2b_second: seen=%b cur=%0d want 1 %0d", seen, bus.cur_pwr_state, exp_v);
    end
    repeat (5) step();
    n_run++;
    if (done_cnt - d0 != 2) begin
      n_fail++;
      $display("FAIL b2b_pulses: pulses=%0d want 2", done_cnt - d0);
    end
  endtask

  task automatic test_reserved();
    int d0;
    int bad;
    d0 = done_cnt;
    bad = 0;
    bus.pipe_powerdown = 3'd5 + 3'($urandom_range(0, 2));
    repeat (8) begin
      step();
      if (bus.busy !== 1'b0 || bus.fsm_state !== ST_IDLE) bad++;
    end
    n_run++;
    if (bad != 0 || done_cnt != d0 || bus.cur_pwr_state !== 3'd0) begin
      n_fail++;
      $display("FAIL reserved: bad=%0d pulses=%0d cur=%0d want 0 0 0", bad, done_cnt - d0, bus.cur_pwr_state);
    end
    bus.pipe_powerdown = 3'd0;
  endtask

  task automatic test_pll_drop();
    int d0;
    int cyc;
    bit seen;
    bit fell;
    bus.pipe_powerdown = 3'd2;
    exp_q.push_back(3'd2);
    wait_done(20, cyc, seen);
    step();
    exp_v = exp_q.pop_front();
    n_run++;
    if (!seen || bus.cur_pwr_state !== exp_v) begin
      n_fail++;
      $display("FAIL drop_pre: seen=%b cur=%0d want 1 %0d", seen, bus.cur_pwr_state, exp_v);
    end
    man_clk_ack = 1'b0;
    man_clk_en = 1'b1;
    bus.pipe_powerdown = 3'd0;
    cyc = 0;
    while (bus.fsm_state !== ST_CLK_ON && cyc < 10) begin
      step();
      cyc++;
    end
    step();
    step();
    n_run++;
    if (bus.fsm_state !== ST_CLK_ON || bus.pma_xcvr_pll_clk_en !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_clk_on: st=%0d clk_en=%b want %0d 1", bus.fsm_state, bus.pma_xcvr_pll_clk_en, ST_CLK_ON);
    end
    d0 = done_cnt;
    bus.pma_pll_ready = 1'b0;
    bus.pipe_powerdown = 3'd3;
    step();
    check_reset_values("drop_wait_pll");
    man_clk_en = 1'b0;
    repeat (3) step();
    bus.pma_pll_ready = 1'b1;
    cyc = 0;
    fell = 1'b0;
    while (!fell && cyc < 20) begin
      step();
      cyc++;
      if (bus.busy === 1'b0) fell = 1'b1;
    end
    n_run++;
    if (!fell || bus.pma_power_state_req !== 6'h08 || bus.cur_pwr_state !== 3'd3 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL drop_replay: idle=%b req=%h cur=%0d pulses=%0d want 1 08 3 0",
               fell, bus.pma_power_state_req, bus.cur_pwr_state, done_cnt - d0);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    int req_cycles;
    bit early_err;
    bit seen;
    man_ack = 6'h00;
    man_ack_en = 1'b1;
    bus.pipe_powerdown = 3'd2;
    exp_q.push_back(3'd2);
`ifdef CDN_PWR_SEQ_TIMEOUT_EN
    cyc = 0; req_cycles = 0; early_err = 1'b0; seen = 1'b0;
    while (!seen && cyc < 60) begin
      step();
      cyc++;
      if (bus.fsm_state === ST_REQ) begin
        req_cycles++;
        if (bus.pwr_chg_err !== 1'b0) early_err = 1'b1;
      end
      if (bus.pwr_chg_done === 1'b1) seen = 1'b1;
    end
    n_run++;
    if (!seen || req_cycles != 16 || early_err || bus.pwr_chg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_fire: done=%b req_cycles=%0d early=%b err=%b want 1 16 0 1",
               seen, req_cycles, early_err, bus.pwr_chg_err);
    end
`else
    repeat (40) step();
    n_run++;
    if (bus.fsm_state !== ST_REQ || bus.pwr_chg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_wait: st=%0d err=%b want %0d 0", bus.fsm_state, bus.pwr_chg_err, ST_REQ);
    end
    man_ack = 6'h04;
    wait_done(10, cyc, seen);
    n_run++;
    if (!seen || cyc != 1) begin
      n_fail++;
      $display("FAIL tmo_release: seen=%b cycles=%0d want 1 1", seen, cyc);
    end
`endif
    step();
    exp_v = exp_q.pop_front();
    man_ack_en = 1'b0;
    repeat (5) step();
    n_run++;
`ifdef CDN_PWR_SEQ_TIMEOUT_EN
    if (bus.cur_pwr_state !== exp_v || bus.pwr_chg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_sticky: cur=%0d err=%b want %0d 1", bus.cur_pwr_state, bus.pwr_chg_err, exp_v);
    end
`else
    if (bus.cur_pwr_state !== exp_v || bus.pwr_chg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_sticky: cur=%0d err=%b want %0d 0", bus.cur_pwr_state, bus.pwr_chg_err, exp_v);
    end
`endif
  endtask

  task automatic test_reset_mid();
    bus.pipe_powerdown = 3'd0;
    step();
    step();
    n_run++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: busy=%b want 1", bus.busy);
    end
    rst = 1'b1;
    step();
    check_reset_values("mid_reset");
    rst = 1'b0;
    bus.pma_pll_ready = 1'b0;
    step();
  endtask

  // test sequence and final report
  initial begin
    bus.pipe_powerdown = 3'd3;
    bus.pma_pll_ready = 1'b0;
    test_reset();
    test_p2_to_p0();
    test_p0_to_p0s();
    test_delayed_ack();
    test_back_to_back();
    test_reserved();
    test_pll_drop();
    test_timeout();
    test_reset_mid();
    n_run++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
